// File: rtl/fifo_flush_sched_if.sv
// Handshake bundle between the flush scheduler, the four nibble producers,
// the FIFO flush datapath and the downstream word consumer.
interface fifo_flush_sched_if;
  logic [3:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        fifo_wr_valid_o;
  logic [3:0]  fifo_wr_data_o;
  logic        fifo_full_i;
  logic        fifo_empty_i;
  logic        fifo_flush_o;
  logic [31:0] fifo_rd_data_i;
  logic        flush_req_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_count_o;
  logic        out_ready_i;

  modport master (
    output req_valid_i, req_data_i, fifo_full_i, fifo_empty_i,
           fifo_rd_data_i, flush_req_i, out_ready_i,
    input  req_ready_o, fifo_wr_valid_o, fifo_wr_data_o, fifo_flush_o,
           out_valid_o, out_data_o, out_count_o
  );

  modport slave (
    input  req_valid_i, req_data_i, fifo_full_i, fifo_empty_i,
           fifo_rd_data_i, flush_req_i, out_ready_i,
    output req_ready_o, fifo_wr_valid_o, fifo_wr_data_o, fifo_flush_o,
           out_valid_o, out_data_o, out_count_o
  );
endinterface

// File: rtl/fifo_flush_sched.sv
// Flush scheduler: round-robin nibble arbitration into the FIFO, flush
// triggering (threshold / software / idle timeout) and word hand-off.
module fifo_flush_sched #(
  parameter int FLUSH_HOLD = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  fifo_flush_sched_if.slave bus
);

  localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  typedef enum logic [1:0] {FILL, FLUSH, OUT} state_t;

  state_t       state_q, state_d;
  logic [5:0]   pend_q;
  logic [4:0]   idle_q;
  logic [1:0]   rr_q;
  logic [HW-1:0] hold_q;
  logic [31:0]  out_data_q;
  logic [3:0]   out_count_q;

  logic         pend_nz;
  logic         trigger;
  logic         can_grant;
  logic         found;
  logic [1:0]   gidx;
  logic [1:0]   scan_idx;
  logic [3:0]   grant;
  logic         hold_last;
  logic [3:0]   take;
  logic         unused_status;

  // Empty flag is informational only; nothing in the scheduler gates on it.
  assign unused_status = bus.fifo_empty_i;

  assign pend_nz   = (pend_q != 6'd0);
  assign trigger   = (state_q == FILL) &&
                     ((pend_q >= 6'd8) ||
                      (bus.flush_req_i && pend_nz) ||
                      ((idle_q == 5'(TIMEOUT)) && pend_nz));
  assign can_grant = (state_q == FILL) && !reset && !bus.fifo_full_i &&
                     (pend_q < 6'd31) && !trigger;
  assign hold_last = (hold_q == HW'(FLUSH_HOLD - 1));
  assign take      = (pend_q >= 6'd8) ? 4'd8 : pend_q[3:0];

  always_comb begin
    grant    = 4'b0000;
    gidx     = 2'd0;
    found    = 1'b0;
    scan_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!found && can_grant && bus.req_valid_i[scan_idx]) begin
        found          = 1'b1;
        grant[scan_idx] = 1'b1;
        gidx           = scan_idx;
      end
    end
  end

  assign bus.req_ready_o     = grant;
  assign bus.fifo_wr_valid_o = found;
  assign bus.fifo_wr_data_o  = found ? bus.req_data_i[{gidx, 2'b00} +: 4] : 4'h0;
  assign bus.fifo_flush_o    = (state_q == FLUSH);
  assign bus.out_valid_o     = (state_q == OUT);
  assign bus.out_data_o      = out_data_q;
  assign bus.out_count_o     = out_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (trigger) state_d = FLUSH;
      FLUSH:   if (hold_last) state_d = OUT;
      OUT:     if (bus.out_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      pend_q      <= 6'd0;
      idle_q      <= 5'd0;
      rr_q        <= 2'd0;
      hold_q      <= '0;
      out_data_q  <= 32'd0;
      out_count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FILL: begin
          hold_q <= '0;
          if (found) begin
            pend_q <= pend_q + 6'd1;
            idle_q <= 5'd0;
            rr_q   <= gidx + 2'd1;
          end else if (pend_nz && (idle_q != 5'd31)) begin
            idle_q <= idle_q + 5'd1;
          end
        end
        FLUSH: begin
          hold_q <= hold_q + HW'(1);
          // The datapath presents the flushed word only in the final hold cycle.
          if (hold_last) begin
            out_data_q  <= bus.fifo_rd_data_i;
            out_count_q <= take;
            pend_q      <= pend_q - {2'b00, take};
            idle_q      <= 5'd0;
            hold_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
